// File: rtl/quad_decoder_counter.sv
`default_nettype none
// ============================================================================
// Module      : quad_decoder_counter
// Description : Synchronised, glitch-filtered x4 quadrature decoder with
//               position count, direction/idle reporting and illegal-step flag.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_decoder_counter #(
    parameter int WIDTH       = 16,
    parameter int FILTER_LEN  = 2,
    parameter int SATURATE    = 0,
    parameter int IDLE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A,
    input  logic             B,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       dir,
    output logic             step,
    output logic             err
);

    localparam int c_TMR_W  = $clog2(IDLE_CYCLES + 1);
    localparam int c_WARM   = FILTER_LEN + 4;
    localparam int c_WARM_W = $clog2(c_WARM + 1);

    logic [1:0] r_ab_meta;
    logic [1:0] r_ab_sync;
    logic [1:0] w_ab_filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ab_meta <= 2'b00;
            r_ab_sync <= 2'b00;
        end else begin
            r_ab_meta <= {A, B};
            r_ab_sync <= r_ab_meta;
        end
    end

    generate
        if (FILTER_LEN == 0) begin : g_bypass
            logic [1:0] r_ab_filt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_ab_filt <= 2'b00;
                else        r_ab_filt <= r_ab_sync;
            end
            assign w_ab_filt = r_ab_filt;
        end else begin : g_filter
            localparam int c_FCNT_W = $clog2(FILTER_LEN + 1);
            logic [c_FCNT_W-1:0] r_fcnt;
            logic [1:0]          r_ab_seen;
            logic [1:0]          r_ab_filt;
            // r_fcnt = consecutive cycles the current differing value has been seen
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_fcnt    <= '0;
                    r_ab_seen <= 2'b00;
                    r_ab_filt <= 2'b00;
                end else begin
                    r_ab_seen <= r_ab_sync;
                    if (r_ab_sync == r_ab_filt) begin
                        r_fcnt <= '0;
                    end else if (r_ab_sync != r_ab_seen) begin
                        r_fcnt <= c_FCNT_W'(1);
                    end else if (r_fcnt == c_FCNT_W'(FILTER_LEN)) begin
                        r_ab_filt <= r_ab_sync;
                        r_fcnt    <= '0;
                    end else begin
                        r_fcnt <= r_fcnt + c_FCNT_W'(1);
                    end
                end
            end
            assign w_ab_filt = r_ab_filt;
        end
    endgenerate

    logic [1:0]          r_ab_prev;
    logic [c_WARM_W-1:0] r_warm;
    logic [c_TMR_W-1:0]  r_timer;
    logic [c_TMR_W-1:0]  w_timer_inc;
    logic [1:0]          w_idx_cur;
    logic [1:0]          w_idx_prev;
    logic [1:0]          w_diff;
    logic                w_warm_done;
    logic                w_fwd;
    logic                w_bwd;
    logic                w_illegal;
    logic [WIDTH-1:0]    w_count_next;

    // Gray AB -> phase index along the horario sequence 00,10,11,01
    assign w_idx_cur   = {w_ab_filt[0], w_ab_filt[1] ^ w_ab_filt[0]};
    assign w_idx_prev  = {r_ab_prev[0], r_ab_prev[1] ^ r_ab_prev[0]};
    assign w_diff      = w_idx_cur - w_idx_prev;
    assign w_warm_done = (r_warm == c_WARM_W'(c_WARM));
    assign w_fwd       = w_warm_done && (w_diff == 2'd1);
    assign w_bwd       = w_warm_done && (w_diff == 2'd3);
    assign w_illegal   = w_warm_done && (w_diff == 2'd2);
    assign w_timer_inc = r_timer + c_TMR_W'(1);

    always_comb begin
        w_count_next = count;
        if (w_fwd) begin
            if (!((SATURATE != 0) && (count == {WIDTH{1'b1}})))
                w_count_next = count + WIDTH'(1);
        end else if (w_bwd) begin
            if (!((SATURATE != 0) && (count == '0)))
                w_count_next = count - WIDTH'(1);
        end
    end

    // Prev AB tracks every cycle (also with en=0) so re-enable never sees a stale step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ab_prev <= 2'b00;
            r_warm    <= '0;
            r_timer   <= '0;
            count     <= '0;
            dir       <= 2'b00;
            step      <= 1'b0;
            err       <= 1'b0;
        end else begin
            step      <= 1'b0;
            r_ab_prev <= w_ab_filt;
            if (!w_warm_done)
                r_warm <= r_warm + c_WARM_W'(1);
            if (clr) begin
                count   <= '0;
                dir     <= 2'b00;
                err     <= 1'b0;
                r_timer <= '0;
            end else begin
                if (w_illegal)
                    err <= 1'b1;
                if (en) begin
                    if (w_fwd || w_bwd) begin
                        count   <= w_count_next;
                        dir     <= w_fwd ? 2'b01 : 2'b10;
                        step    <= 1'b1;
                        r_timer <= '0;
                    end else if (r_timer != c_TMR_W'(IDLE_CYCLES)) begin
                        r_timer <= w_timer_inc;
                        if (w_timer_inc == c_TMR_W'(IDLE_CYCLES))
                            dir <= 2'b00;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
